vga_sync_rx: RTL and testbench
==============================

VGA_SYNC_RX -- requirements
Module: vga_sync_rx

Interface
REQ-001 The block SHALL take parameter H_SYNC, default 128, meaning hsync pulse width in clocks.
REQ-002 The block SHALL take parameter H_BP, default 88, meaning horizontal back porch in clocks.
REQ-003 The block SHALL take parameter H_ACT, default 800, meaning active pixels per line.
REQ-004 The block SHALL take parameter V_SYNC, default 4, meaning vsync pulse width in lines.
REQ-005 The block SHALL take parameter V_BP, default 23, meaning vertical back porch in lines.
REQ-006 The block SHALL take parameter V_ACT, default 600, meaning active lines per frame.
REQ-007 The block SHALL take parameter SYNC_POL, default 1'b0, meaning the asserted level of hsync and vsync.
REQ-008 The block SHALL have port clk  input  1  pixel clock (40 MHz VGA_CLK domain).
REQ-009 The block SHALL have port rst_n  input  1  reset; one clock, asynchronous active-low reset.
REQ-010 The block SHALL have port hsync  input  1  horizontal sync from the VGA source.
REQ-011 The block SHALL have port vsync  input  1  vertical sync from the VGA source.
REQ-012 The block SHALL have port x  output  11  active-area column, 0..H_ACT-1.
REQ-013 The block SHALL have port y  output  10  active-area row, 0..V_ACT-1.
REQ-014 The block SHALL have port de  output  1  high when (x,y) is inside the active area and locked.
REQ-015 The block SHALL have port frame_start  output  1  one-cycle pulse at the vsync leading edge.
REQ-016 The block SHALL have port locked  output  1  timing is stable.
REQ-017 The block SHALL have port h_total  output  12  last measured line period in clocks.
REQ-018 The block SHALL have port v_total  output  11  last measured frame period in lines.
REQ-019 The block SHALL have port err  output  1  one-cycle pulse on loss of lock.

Function
REQ-020 hsync and vsync SHALL be registered once; all edge detection SHALL use the registered copies hs_r and vs_r, so outputs lag the pins by exactly 1 clock.
REQ-021 The leading edge SHALL be the first cycle in which the registered sync equals SYNC_POL after not equalling it.
REQ-022 hcnt (12 bit) SHALL be 0 in the hsync leading-edge cycle and SHALL otherwise increment, saturating at 4095.
REQ-023 At each hsync leading edge, h_total SHALL load hcnt+1 of the line just ended; the first edge after reset SHALL not load.
REQ-024 A vsync leading edge SHALL set a pending flag; vcnt SHALL clear to 0 at the next hsync leading edge, or in the same cycle if both edges coincide, and SHALL otherwise increment at each hsync leading edge, saturating at 2047.
REQ-025 When vcnt clears, v_total SHALL load the previous vcnt+1.
REQ-026 x SHALL equal hcnt-(H_SYNC+H_BP) and y SHALL equal vcnt-(V_SYNC+V_BP) whenever both are inside the active window; otherwise x and y SHALL hold 0.
REQ-027 de SHALL be high only when locked=1 and both counters are inside the active window.
REQ-028 The FSM SHALL have states SEARCH, HLOCK and LOCKED.
REQ-029 SEARCH SHALL move to HLOCK after 2 consecutive equal line periods.
REQ-030 HLOCK SHALL move to LOCKED after 2 consecutive equal frame periods with no line-period change.
REQ-031 locked SHALL be 1 only in LOCKED.
REQ-032 In HLOCK or LOCKED, a line period that differs from h_total, or a counter saturation, SHALL return the FSM to SEARCH.
REQ-033 A frame period that differs from v_total SHALL return the FSM to SEARCH.
REQ-034 err SHALL pulse for one cycle when the FSM leaves LOCKED.
REQ-035 frame_start SHALL pulse in the vs_r leading-edge cycle regardless of lock state.

Reset
REQ-036 On rst_n low, asynchronously: FSM=SEARCH; x=0, y=0, de=0, frame_start=0, locked=0, err=0, h_total=0, v_total=0; hcnt, vcnt and the pending flag cleared; hs_r and vs_r set to ~SYNC_POL.
REQ-037 Reset asserted mid-frame SHALL discard all measurements; relock SHALL require the full REQ-029/REQ-030 sequence.

Structure
REQ-038 The FSM state encoding and the 800x600@60 default timing constants SHALL live in shared package vga_pkg, reused by the vga_data8 generator.
REQ-039 One sub-module vga_edge_det (register plus leading-edge pulse, parameter POL) SHALL be instantiated twice, once per sync input.

Verification
REQ-040 Drive the vga_data8 timing for 3 frames -> locked=1 by the third frame start, h_total=1056, v_total=628.
REQ-041 In lock, the first active clock -> x=0, y=0, de=1; the last active clock -> x=799, y=599; the next clock -> de=0.
REQ-042 In lock, stretch one line to 1057 clocks -> err pulses once, locked=0, de=0, and relock after 2 clean frames.
REQ-043 Make the vsync and hsync leading edges coincident -> vcnt=0 in that cycle and frame_start=1 for exactly 1 clock.
REQ-044 Assert rst_n low mid-line at y=300 -> all outputs 0 asynchronously, and after release the block stays in SEARCH until 2 equal lines are seen.
REQ-045 Hold hsync deasserted for 5000 clocks -> hcnt saturates at 4095, FSM=SEARCH, and no X values appear on any output.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing package: lock FSM encoding and the 800x600@60 (40 MHz) default timing.
// The vga_data8 pattern generator reuses these constants.
package vga_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        HLOCK  = 2'd1,
        LOCKED = 2'd2
    } sync_state_t;

    localparam int H_SYNC_800 = 128;
    localparam int H_BP_800   = 88;
    localparam int H_ACT_800  = 800;
    localparam int H_FP_800   = 40;
    localparam int H_TOT_800  = H_SYNC_800 + H_BP_800 + H_ACT_800 + H_FP_800;

    localparam int V_SYNC_600 = 4;
    localparam int V_BP_600   = 23;
    localparam int V_ACT_600  = 600;
    localparam int V_FP_600   = 1;
    localparam int V_TOT_600  = V_SYNC_600 + V_BP_600 + V_ACT_600 + V_FP_600;

endpackage

// File: rtl/vga_edge_det.sv
// Sync input register with leading-edge detection toward polarity POL.
// o_lead_next flags the edge one clock early so counters can be zero in the edge cycle.
module vga_edge_det #(
    parameter logic POL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sync,
    output logic o_lead_next,
    output logic o_lead
);

    logic r_sync;
    logic r_lead;

    assign o_lead_next = (i_sync == POL) && (r_sync != POL);
    assign o_lead      = r_lead;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= ~POL;
            r_lead <= 1'b0;
        end else begin
            r_sync <= i_sync;
            r_lead <= o_lead_next;
        end
    end

endmodule

// File: rtl/vga_sync_rx.sv
// VGA sync receiver: measures line/frame periods from hsync/vsync, locks onto stable
// timing and produces active-area coordinates and data enable.
module vga_sync_rx
    import vga_pkg::*;
#(
    parameter int   H_SYNC   = H_SYNC_800,
    parameter int   H_BP     = H_BP_800,
    parameter int   H_ACT    = H_ACT_800,
    parameter int   V_SYNC   = V_SYNC_600,
    parameter int   V_BP     = V_BP_600,
    parameter int   V_ACT    = V_ACT_600,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsync,
    input  logic        vsync,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        de,
    output logic        frame_start,
    output logic        locked,
    output logic [11:0] h_total,
    output logic [10:0] v_total,
    output logic        err
);

    localparam logic [11:0] H_START  = 12'(H_SYNC + H_BP);
    localparam logic [11:0] H_END    = 12'(H_SYNC + H_BP + H_ACT);
    localparam logic [10:0] V_START  = 11'(V_SYNC + V_BP);
    localparam logic [10:0] V_END    = 11'(V_SYNC + V_BP + V_ACT);
    localparam logic [11:0] HCNT_MAX = 12'hFFF;
    localparam logic [10:0] VCNT_MAX = 11'h7FF;

    logic        w_hs_lead_next;
    logic        w_hs_lead;
    logic        w_vs_lead_next;
    logic        w_vs_lead;

    logic [11:0] r_hcnt;
    logic [10:0] r_vcnt;
    logic [11:0] r_h_total;
    logic [10:0] r_v_total;
    logic        r_seen_h;
    logic        r_h_meas;
    logic        r_seen_v;
    logic        r_v_meas;
    logic        r_vpend;
    logic        r_err;
    sync_state_t r_state;
    sync_state_t w_state_next;

    logic [11:0] w_hperiod;
    logic [10:0] w_vperiod;
    logic        w_hsat;
    logic        w_vsat;
    logic        w_vclear;
    logic        w_hload;
    logic        w_vload;
    logic        w_win;

    vga_edge_det #(.POL(SYNC_POL)) u_hs_edge (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_sync      (hsync),
        .o_lead_next (w_hs_lead_next),
        .o_lead      (w_hs_lead)
    );

    vga_edge_det #(.POL(SYNC_POL)) u_vs_edge (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_sync      (vsync),
        .o_lead_next (w_vs_lead_next),
        .o_lead      (w_vs_lead)
    );

    // Periods are count+1 of the interval just ended, pinned at the counter ceiling.
    assign w_hsat    = (r_hcnt == HCNT_MAX);
    assign w_vsat    = (r_vcnt == VCNT_MAX);
    assign w_hperiod = w_hsat ? HCNT_MAX : r_hcnt + 12'd1;
    assign w_vperiod = w_vsat ? VCNT_MAX : r_vcnt + 11'd1;
    assign w_vclear  = w_hs_lead_next && (r_vpend || w_vs_lead_next);
    assign w_hload   = w_hs_lead_next && r_seen_h;
    assign w_vload   = w_vclear && r_seen_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt    <= '0;
            r_vcnt    <= '0;
            r_h_total <= '0;
            r_v_total <= '0;
            r_seen_h  <= 1'b0;
            r_h_meas  <= 1'b0;
            r_seen_v  <= 1'b0;
            r_v_meas  <= 1'b0;
            r_vpend   <= 1'b0;
        end else begin
            r_hcnt <= w_hs_lead_next ? 12'd0 : w_hperiod;

            if (w_vclear) begin
                r_vcnt <= '0;
            end else if (w_hs_lead_next) begin
                r_vcnt <= w_vperiod;
            end

            if (w_vclear) begin
                r_vpend <= 1'b0;
            end else if (w_vs_lead_next) begin
                r_vpend <= 1'b1;
            end

            if (w_hs_lead) begin
                r_seen_h <= 1'b1;
            end
            if (w_hload) begin
                r_h_total <= w_hperiod;
                r_h_meas  <= 1'b1;
            end

            if (w_vclear) begin
                r_seen_v <= 1'b1;
            end
            if (w_vload) begin
                r_v_total <= w_vperiod;
            end

            // A frame reference only counts once measured outside SEARCH.
            if (w_state_next == SEARCH) begin
                r_v_meas <= 1'b0;
            end else if (w_vload) begin
                r_v_meas <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SEARCH: begin
                if (w_hload && r_h_meas && !w_hsat && (w_hperiod == r_h_total)) begin
                    w_state_next = HLOCK;
                end
            end
            HLOCK, LOCKED: begin
                if (w_hsat || w_vsat || (w_hload && (w_hperiod != r_h_total))) begin
                    w_state_next = SEARCH;
                end else if (w_vload && r_v_meas) begin
                    w_state_next = (w_vperiod == r_v_total) ? LOCKED : SEARCH;
                end
            end
            default: begin
                w_state_next = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SEARCH;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_err   <= (r_state == LOCKED) && (w_state_next != LOCKED);
        end
    end

    assign w_win = (r_hcnt >= H_START) && (r_hcnt < H_END) &&
                   (r_vcnt >= V_START) && (r_vcnt < V_END);

    assign x           = w_win ? 11'(r_hcnt - H_START) : 11'd0;
    assign y           = w_win ? 10'(r_vcnt - V_START) : 10'd0;
    assign locked      = (r_state == LOCKED);
    assign de          = locked && w_win;
    assign frame_start = w_vs_lead;
    assign h_total     = r_h_total;
    assign v_total     = r_v_total;
    assign err         = r_err;

endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx using a scaled-down 32x12 timing so whole frames fit
// in a short run; every expected value is hand-derived from that timing.
module tb_vga_sync_rx;
    import vga_pkg::*;

    localparam int   T_HS   = 8;
    localparam int   T_HBP  = 4;
    localparam int   T_HACT = 16;
    localparam int   T_HTOT = 32;
    localparam int   T_VS   = 2;
    localparam int   T_VBP  = 3;
    localparam int   T_VACT = 6;
    localparam int   T_VTOT = 12;
    localparam logic POL    = 1'b0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsync;
    logic        vsync;
    logic [10:0] x;
    logic [9:0]  y;
    logic        de;
    logic        frame_start;
    logic        locked;
    logic [11:0] h_total;
    logic [10:0] v_total;
    logic        err;

    int nVec = 0;
    int nMiss = 0;
    int hc = 0;
    int vc = 0;
    int curHc = -1;
    int curVc = -1;
    int obsHc = -1;
    int obsVc = -1;
    int stretchVc = -1;
    int errSeen = 0;

    vga_sync_rx #(
        .H_SYNC(T_HS), .H_BP(T_HBP), .H_ACT(T_HACT),
        .V_SYNC(T_VS), .V_BP(T_VBP), .V_ACT(T_VACT), .SYNC_POL(POL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync),
        .x(x), .y(y), .de(de), .frame_start(frame_start), .locked(locked),
        .h_total(h_total), .v_total(v_total), .err(err)
    );

    always #5 clk = ~clk;

    // One pixel per negedge; outputs seen here belong to the pixel driven one clock earlier.
    task automatic step();
        @(negedge clk);
        obsHc = curHc;
        obsVc = curVc;
        if (err === 1'b1) errSeen++;
        hsync = (hc < T_HS) ? POL : ~POL;
        vsync = (vc < T_VS) ? POL : ~POL;
        curHc = hc;
        curVc = vc;
        hc++;
        if (hc == ((vc == stretchVc) ? T_HTOT + 1 : T_HTOT)) begin
            if (vc == stretchVc) stretchVc = -1;
            hc = 0;
            vc = (vc + 1) % T_VTOT;
        end
    endtask

    task automatic wait_pixel(input int h, input int v);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(obsHc == h && obsVc == v) && n < 2000);
        nVec++;
        if (!(obsHc == h && obsVc == v)) begin
            nMiss++;
            $display("[TB] FAIL wait_pixel: reached (%0d,%0d), required (%0d,%0d)", obsHc, obsVc, h, v);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        hsync = ~POL;
        vsync = ~POL;
        repeat (3) @(negedge clk);
        nVec++;
        if ({x, y, de, frame_start, locked, h_total, v_total, err} !== 48'd0) begin
            nMiss++;
            $display("[TB] FAIL reset_outputs: got %h, required 0", {x, y, de, frame_start, locked, h_total, v_total, err});
        end
        nVec++;
        if (dut.r_state !== SEARCH) begin
            nMiss++;
            $display("[TB] FAIL reset_state: got %0d, required %0d", dut.r_state, SEARCH);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_lock();
        wait_pixel(0, 0);
        nVec++;
        if (frame_start !== 1'b1 || locked !== 1'b0 || h_total !== 12'd0) begin
            nMiss++;
            $display("[TB] FAIL lock_f1: fs=%0b locked=%0b h_total=%0d, required 1/0/0", frame_start, locked, h_total);
        end
        wait_pixel(0, 1);
        nVec++;
        if (h_total !== 12'd32 || dut.r_state !== SEARCH) begin
            nMiss++;
            $display("[TB] FAIL lock_line1: h_total=%0d state=%0d, required 32/%0d", h_total, dut.r_state, SEARCH);
        end
        wait_pixel(0, 2);
        nVec++;
        if (dut.r_state !== HLOCK) begin
            nMiss++;
            $display("[TB] FAIL lock_hlock: state=%0d, required %0d", dut.r_state, HLOCK);
        end
        wait_pixel(0, 0);
        nVec++;
        if (frame_start !== 1'b1 || locked !== 1'b0 || v_total !== 11'd12) begin
            nMiss++;
            $display("[TB] FAIL lock_f2: fs=%0b locked=%0b v_total=%0d, required 1/0/12", frame_start, locked, v_total);
        end
        wait_pixel(0, 0);
        nVec++;
        if (locked !== 1'b1 || h_total !== 12'd32 || v_total !== 11'd12) begin
            nMiss++;
            $display("[TB] FAIL lock_f3: locked=%0b h_total=%0d v_total=%0d, required 1/32/12", locked, h_total, v_total);
        end
    endtask

    task automatic test_active();
        int bad = 0;
        logic [10:0] ex;
        logic [9:0]  ey;
        logic        ed;
        wait_pixel(12, 5);
        nVec++;
        if (x !== 11'd0 || y !== 10'd0 || de !== 1'b1) begin
            nMiss++;
            $display("[TB] FAIL active_first: x=%0d y=%0d de=%0b, required 0/0/1", x, y, de);
        end
        wait_pixel(27, 10);
        nVec++;
        if (x !== 11'd15 || y !== 10'd5 || de !== 1'b1) begin
            nMiss++;
            $display("[TB] FAIL active_last: x=%0d y=%0d de=%0b, required 15/5/1", x, y, de);
        end
        step();
        nVec++;
        if (de !== 1'b0 || x !== 11'd0) begin
            nMiss++;
            $display("[TB] FAIL active_after: x=%0d de=%0b, required 0/0", x, de);
        end
        for (int i = 0; i < T_HTOT * T_VTOT; i++) begin
            step();
            ed = (obsHc >= 12 && obsHc < 28 && obsVc >= 5 && obsVc < 11);
            ex = ed ? 11'(obsHc - 12) : 11'd0;
            ey = ed ? 10'(obsVc - 5) : 10'd0;
            if (x !== ex || y !== ey || de !== ed) bad++;
        end
        nVec++;
        if (bad != 0) begin
            nMiss++;
            $display("[TB] FAIL active_frame: %0d pixels wrong, required 0", bad);
        end
    endtask

    task automatic test_stretch();
        wait_pixel(0, 1);
        stretchVc = 3;
        errSeen = 0;
        wait_pixel(0, 4);
        nVec++;
        if (err !== 1'b1 || locked !== 1'b0 || h_total !== 12'd33) begin
            nMiss++;
            $display("[TB] FAIL stretch_edge: err=%0b locked=%0b h_total=%0d, required 1/0/33", err, locked, h_total);
        end
        wait_pixel(12, 5);
        nVec++;
        if (de !== 1'b0 || err !== 1'b0) begin
            nMiss++;
            $display("[TB] FAIL stretch_de: de=%0b err=%0b, required 0/0", de, err);
        end
        wait_pixel(0, 0);
        nVec++;
        if (locked !== 1'b0 || dut.r_state !== HLOCK) begin
            nMiss++;
            $display("[TB] FAIL stretch_f1: locked=%0b state=%0d, required 0/%0d", locked, dut.r_state, HLOCK);
        end
        wait_pixel(0, 0);
        nVec++;
        if (locked !== 1'b1) begin
            nMiss++;
            $display("[TB] FAIL stretch_relock: locked=%0b, required 1", locked);
        end
        nVec++;
        if (errSeen != 1) begin
            nMiss++;
            $display("[TB] FAIL stretch_err_count: %0d pulses, required 1", errSeen);
        end
    endtask

    task automatic test_coincident();
        wait_pixel(31, 11);
        nVec++;
        if (frame_start !== 1'b0) begin
            nMiss++;
            $display("[TB] FAIL coinc_before: fs=%0b, required 0", frame_start);
        end
        step();
        nVec++;
        if (frame_start !== 1'b1 || dut.r_vcnt !== 11'd0) begin
            nMiss++;
            $display("[TB] FAIL coinc_edge: fs=%0b vcnt=%0d, required 1/0", frame_start, dut.r_vcnt);
        end
        step();
        nVec++;
        if (frame_start !== 1'b0) begin
            nMiss++;
            $display("[TB] FAIL coinc_after: fs=%0b, required 0", frame_start);
        end
        wait_pixel(0, 1);
        nVec++;
        if (dut.r_vcnt !== 11'd1 || locked !== 1'b1) begin
            nMiss++;
            $display("[TB] FAIL coinc_line1: vcnt=%0d locked=%0b, required 1/1", dut.r_vcnt, locked);
        end
    endtask

    task automatic test_reset_midframe();
        wait_pixel(20, 8);
        nVec++;
        if (y !== 10'd3 || x !== 11'd8 || locked !== 1'b1) begin
            nMiss++;
            $display("[TB] FAIL mid_before: x=%0d y=%0d locked=%0b, required 8/3/1", x, y, locked);
        end
        #2 rst_n = 1'b0;
        #1;
        nVec++;
        if ({x, y, de, frame_start, locked, h_total, v_total, err} !== 48'd0) begin
            nMiss++;
            $display("[TB] FAIL mid_async: got %h, required 0", {x, y, de, frame_start, locked, h_total, v_total, err});
        end
        repeat (3) step();
        rst_n = 1'b1;
        wait_pixel(0, 9);
        nVec++;
        if (dut.r_state !== SEARCH || h_total !== 12'd0) begin
            nMiss++;
            $display("[TB] FAIL mid_edge1: state=%0d h_total=%0d, required %0d/0", dut.r_state, h_total, SEARCH);
        end
        wait_pixel(0, 10);
        nVec++;
        if (dut.r_state !== SEARCH || h_total !== 12'd32) begin
            nMiss++;
            $display("[TB] FAIL mid_edge2: state=%0d h_total=%0d, required %0d/32", dut.r_state, h_total, SEARCH);
        end
        wait_pixel(0, 11);
        nVec++;
        if (dut.r_state !== HLOCK || locked !== 1'b0) begin
            nMiss++;
            $display("[TB] FAIL mid_edge3: state=%0d locked=%0b, required %0d/0", dut.r_state, locked, HLOCK);
        end
    endtask

    task automatic test_saturation();
        int errPulses = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (err === 1'b1) errPulses++;
            hsync = ~POL;
            vsync = ~POL;
        end
        nVec++;
        if (dut.r_hcnt !== 12'd4095 || dut.r_state !== SEARCH) begin
            nMiss++;
            $display("[TB] FAIL sat_state: hcnt=%0d state=%0d, required 4095/%0d", dut.r_hcnt, dut.r_state, SEARCH);
        end
        nVec++;
        if ($isunknown({x, y, de, frame_start, locked, h_total, v_total, err}) || locked !== 1'b0 || de !== 1'b0) begin
            nMiss++;
            $display("[TB] FAIL sat_outputs: locked=%0b de=%0b bits=%b, required clean 0/0", locked, de, {x, y, de, frame_start, locked, h_total, v_total, err});
        end
        nVec++;
        if (errPulses != 0) begin
            nMiss++;
            $display("[TB] FAIL sat_err: %0d pulses leaving HLOCK, required 0", errPulses);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        hsync = ~POL;
        vsync = ~POL;
        test_reset();
        test_lock();
        test_active();
        test_stretch();
        test_coincident();
        test_reset_midframe();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
